// File: rtl/retire_trace_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// retire_trace_ctrl_pkg
//   Shared types and constants for the retire trace controller.
//   - INST_RETIRE_WD : width of one retire record.
//   - retire_rec_t   : record layout {pc, wen, dest, wdata}.
//   - rt_state_e     : serializer states (IDLE, then one state per trace word).
//   - meta_word()    : builds the middle trace word from a record.
// ----------------------------------------------------------------------------
package retire_trace_ctrl_pkg;

    localparam int INST_RETIRE_WD = 70;
    localparam int TRACE_WD       = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  dest;
        logic [31:0] wdata;
    } retire_rec_t;

    typedef enum logic [1:0] {
        RT_IDLE = 2'd0,
        RT_W0   = 2'd1,
        RT_W1   = 2'd2,
        RT_W2   = 2'd3
    } rt_state_e;

    function automatic logic [TRACE_WD-1:0] meta_word(input retire_rec_t rec);
        return {26'b0, rec.wen, rec.dest};
    endfunction

endpackage

// File: rtl/retire_trace_ctrl_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO holding retire records. The head entry is presented
//   combinationally; a write is never visible at the head in the same cycle.
//   Ports:
//     i_clk, i_rst (sync, active-low)
//     i_push / i_wdata : write request and data (ignored while full)
//     i_pop            : remove the head entry (ignored while empty)
//     o_head           : mem[rd_ptr]
//     o_count          : occupancy 0..DEPTH
//     o_count_next     : occupancy after this cycle's push/pop
//     o_full           : registered (count == DEPTH)
// ----------------------------------------------------------------------------
module sync_fifo
    import retire_trace_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int WIDTH = INST_RETIRE_WD
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [AW:0]      o_count,
    output logic [AW:0]      o_count_next,
    output logic             o_full
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;

    logic             w_push_acc;
    logic             w_pop_acc;
    logic [AW:0]      w_count_next;

    assign w_push_acc = i_push && !r_full;
    assign w_pop_acc  = i_pop && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (w_push_acc && !w_pop_acc) begin
            w_count_next = r_count + (AW+1)'(1);
        end else if (!w_push_acc && w_pop_acc) begin
            w_count_next = r_count - (AW+1)'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == DEPTH_C);
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_push_acc) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_full       = r_full;

endmodule

// File: rtl/retire_trace_ctrl.sv
// ----------------------------------------------------------------------------
// retire_trace_ctrl
//   Buffers retire records from the WB stage and serializes each one onto a
//   32-bit valid/ready trace port as three words: pc, {26'b0,wen,dest}, wdata.
//   Ports:
//     i_clk, i_rst (sync, active-low)
//     i_inst_retire_valid, i_inst_retired : WB push
//     o_inst_retired_fifo_full            : backpressure to WB
//     o_trace_valid, i_trace_ready        : trace handshake
//     o_trace_data, o_trace_last          : current word, last-word flag
//     o_fifo_count                        : FIFO occupancy
//     o_drop_cnt                          : pushes attempted while full
// ----------------------------------------------------------------------------
module retire_trace_ctrl
    import retire_trace_ctrl_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int REC_WD = INST_RETIRE_WD
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inst_retire_valid,
    input  logic [REC_WD-1:0] i_inst_retired,
    output logic              o_inst_retired_fifo_full,
    output logic              o_trace_valid,
    input  logic              i_trace_ready,
    output logic [31:0]       o_trace_data,
    output logic              o_trace_last,
    output logic [AW:0]       o_fifo_count,
    output logic [31:0]       o_drop_cnt
);

    rt_state_e        r_state;
    rt_state_e        w_state_next;
    logic [31:0]      r_drop_cnt;

    logic [REC_WD-1:0] w_head;
    retire_rec_t       w_head_rec;
    logic [AW:0]       w_count;
    logic [AW:0]       w_count_next;
    logic              w_full;
    logic              w_hs;
    logic              w_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (REC_WD)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (i_inst_retire_valid),
        .i_wdata      (i_inst_retired),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_full       (w_full)
    );

    assign w_head_rec = w_head;
    assign w_hs       = (r_state != RT_IDLE) && i_trace_ready;
    // The record leaves the FIFO only once its last word is taken.
    assign w_pop      = (r_state == RT_W2) && w_hs;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= RT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        o_trace_data  = '0;
        o_trace_last  = 1'b0;
        case (r_state)
            RT_IDLE: begin
                if (w_count != '0) begin
                    w_state_next = RT_W0;
                end
            end
            RT_W0: begin
                o_trace_data = w_head_rec.pc;
                if (w_hs) begin
                    w_state_next = RT_W1;
                end
            end
            RT_W1: begin
                o_trace_data = meta_word(w_head_rec);
                if (w_hs) begin
                    w_state_next = RT_W2;
                end
            end
            RT_W2: begin
                o_trace_data = w_head_rec.wdata;
                o_trace_last = 1'b1;
                // Chain straight into the next record when one is waiting,
                // counting a push that lands on the same edge as the pop.
                if (w_hs) begin
                    w_state_next = (w_count_next != '0) ? RT_W0 : RT_IDLE;
                end
            end
            default: begin
                w_state_next = RT_IDLE;
            end
        endcase
    end

    // A push seen while full is lost even if a pop frees a slot on this edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_drop_cnt <= '0;
        end else if (i_inst_retire_valid && w_full) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign o_trace_valid            = (r_state != RT_IDLE);
    assign o_inst_retired_fifo_full = w_full;
    assign o_fifo_count             = w_count;
    assign o_drop_cnt               = r_drop_cnt;

endmodule

// File: tb/tb_retire_trace_ctrl.sv
module tb_retire_trace_ctrl;
    import retire_trace_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    retire_rec_t in_rec;
    logic        ready;
    logic        full;
    logic        tv;
    logic [31:0] td;
    logic        tl;
    logic [3:0]  cnt;
    logic [31:0] drop;

    int checks = 0;
    int errors = 0;

    retire_rec_t q[$];
    int          wi = 0;
    int          drop_exp = 0;

    always #5 clk = ~clk;

    retire_trace_ctrl #(.DEPTH(8), .AW(3), .REC_WD(70)) dut (
        .i_clk                    (clk),
        .i_rst                    (rst_n),
        .i_inst_retire_valid      (in_valid),
        .i_inst_retired           (in_rec),
        .o_inst_retired_fifo_full (full),
        .o_trace_valid            (tv),
        .i_trace_ready            (ready),
        .o_trace_data             (td),
        .o_trace_last             (tl),
        .o_fifo_count             (cnt),
        .o_drop_cnt               (drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic retire_rec_t mk(input logic [31:0] pc, input logic wen,
                                       input logic [4:0] dest, input logic [31:0] wdata);
        retire_rec_t r;
        r.pc = pc; r.wen = wen; r.dest = dest; r.wdata = wdata;
        return r;
    endfunction

    function automatic logic [31:0] word_of(input retire_rec_t r, input int w);
        if (w == 0) return r.pc;
        if (w == 1) return {26'b0, r.wen, r.dest};
        return r.wdata;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given inputs; checks any word on offer against the
    // scoreboard head, then updates the scoreboard and checks count/drops.
    task automatic cycle(input logic v, input retire_rec_t r, input logic rd);
        bit acc;
        bit hs;
        in_valid = v;
        in_rec   = r;
        ready    = rd;
        if (tv === 1'b1) begin
            chk("valid_with_data", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("trace_data", td, word_of(q[0], wi));
                chk("trace_last", 32'(tl), 32'(wi == 2));
            end
        end
        hs  = (tv === 1'b1) && rd;
        acc = v && (q.size() < 8);
        if (v && !acc) drop_exp++;
        tick();
        in_valid = 1'b0;
        if (hs) begin
            $display("xfer word=%0d data=0x%08h", wi, word_of(q.size() != 0 ? q[0] : '0, wi));
            wi++;
            if (wi == 3) begin
                wi = 0;
                if (q.size() != 0) void'(q.pop_front());
            end
        end
        if (acc) q.push_back(r);
        chk("fifo_count", 32'(cnt), 32'(q.size()));
        chk("drop_cnt", drop, 32'(drop_exp));
    endtask

    task automatic drain(output int n);
        n = 0;
        while (q.size() != 0 && n < 300) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
        chk("idle_after_drain", 32'(tv), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int issued;
        retire_rec_t r;

        // Reset
        rst_n = 1'b0; in_valid = 1'b0; in_rec = '0; ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(tv), 32'd0);
        chk("rst_data", td, 32'd0);
        chk("rst_last", 32'(tl), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_drop", drop, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single record, ready held high
        cycle(1'b1, mk(32'h1000, 1'b1, 5'd5, 32'hDEADBEEF), 1'b1);
        chk("t1_no_bypass", 32'(tv), 32'd0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_w0_valid", 32'(tv), 32'd1);
        chk("t1_w0_data", td, 32'h0000_1000);
        chk("t1_w0_last", 32'(tl), 32'd0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_w1_data", td, 32'h0000_0025);
        chk("t1_w1_last", 32'(tl), 32'd0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_w2_data", td, 32'hDEADBEEF);
        chk("t1_w2_last", 32'(tl), 32'd1);
        cycle(1'b0, '0, 1'b1);
        chk("t1_idle_valid", 32'(tv), 32'd0);
        chk("t1_idle_data", td, 32'd0);

        // 2: fill with ready low, overflow once, then drain
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, mk(32'h2000 + 32'(i * 4), i[0], 5'(i + 1), 32'hA5A5_0000 + 32'(i)), 1'b0);
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count8", 32'(cnt), 32'd8);
        cycle(1'b1, mk(32'hBAD0, 1'b1, 5'd1, 32'hBAD0BAD0), 1'b0);
        chk("t2_drop1", drop, 32'd1);
        chk("t2_count_still8", 32'(cnt), 32'd8);
        drain(n);
        chk("t2_drain_cycles", 32'(n), 32'd24);

        // 3: ready toggling; each word held while ready is low
        cycle(1'b1, mk(32'h3000, 1'b0, 5'd31, 32'h12345678), 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("t3_w0_data", td, 32'h0000_3000);
        cycle(1'b0, '0, 1'b0);
        chk("t3_w0_hold", td, 32'h0000_3000);
        cycle(1'b0, '0, 1'b1);
        chk("t3_w1_data", td, 32'h0000_001F);
        cycle(1'b0, '0, 1'b0);
        chk("t3_w1_hold", td, 32'h0000_001F);
        chk("t3_w1_hold_last", 32'(tl), 32'd0);
        cycle(1'b0, '0, 1'b1);
        chk("t3_w2_data", td, 32'h1234_5678);
        cycle(1'b0, '0, 1'b0);
        chk("t3_w2_hold", td, 32'h1234_5678);
        chk("t3_w2_hold_last", 32'(tl), 32'd1);
        cycle(1'b0, '0, 1'b1);
        chk("t3_idle", 32'(tv), 32'd0);
        chk("t3_empty", 32'(cnt), 32'd0);

        // 4: full FIFO, push coincides with the W2 pop
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, mk(32'h4000 + 32'(i), 1'b1, 5'(i), 32'h4444_0000 + 32'(i)), 1'b0);
        end
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("t4_at_w2", 32'(tl), 32'd1);
        cycle(1'b1, mk(32'hD0D0, 1'b0, 5'd2, 32'hD0D0D0D0), 1'b1);
        chk("t4_drop2", drop, 32'd2);
        chk("t4_count7", 32'(cnt), 32'd7);
        chk("t4_not_full", 32'(full), 32'd0);
        cycle(1'b1, mk(32'h4FFF, 1'b1, 5'd9, 32'h4FFF_4FFF), 1'b0);
        chk("t4_accept_count8", 32'(cnt), 32'd8);
        chk("t4_full_again", 32'(full), 32'd1);
        chk("t4_drop_still2", drop, 32'd2);
        drain(n);
        chk("t4_drain_cycles", 32'(n), 32'd24);

        // 5: reset in W1 with 3 entries queued
        cycle(1'b1, mk(32'h5000, 1'b1, 5'd7, 32'h5555_0001), 1'b0);
        cycle(1'b1, mk(32'h5004, 1'b0, 5'd8, 32'h5555_0002), 1'b0);
        cycle(1'b1, mk(32'h5008, 1'b1, 5'd9, 32'h5555_0003), 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("t5_in_w1", td, 32'h0000_0027);
        ready = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("t5_rst_valid", 32'(tv), 32'd0);
        chk("t5_rst_count", 32'(cnt), 32'd0);
        chk("t5_rst_drop", drop, 32'd0);
        chk("t5_rst_data", td, 32'd0);
        rst_n = 1'b1;
        q.delete();
        wi = 0;
        drop_exp = 0;
        cycle(1'b1, mk(32'h6000, 1'b0, 5'd3, 32'h6666_0000), 1'b1);
        chk("t5_no_bypass", 32'(tv), 32'd0);
        cycle(1'b0, '0, 1'b1);
        chk("t5_first_valid", 32'(tv), 32'd1);
        chk("t5_first_data", td, 32'h0000_6000);
        drain(n);

        // 6: random pushes with random ready
        issued = 0;
        for (int k = 0; k < 400 && issued < 20; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                r = mk($urandom, 1'($urandom), 5'($urandom), $urandom);
                issued++;
                cycle(1'b1, r, 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'b0, '0, 1'($urandom_range(0, 1)));
            end
        end
        chk("t6_issued", 32'(issued), 32'd20);
        drain(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
